// File: rtl/vmem_write_arbiter_pkg.sv
// Shared definitions for the video-memory write arbiter: bus defaults, RGB565 colours,
// {y,x} address packing and the ARB/BURST state encoding.
package vmem_write_arbiter_pkg;

  localparam int VMEM_AW = 16;
  localparam int VMEM_DW = 16;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  function automatic logic [15:0] pack_yx(input logic [7:0] y, input logic [7:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/vmem_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping,
// returned as a one-hot grant plus its index.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_write_arbiter.sv
// Round-robin arbiter sharing the vmem write port between NREQ pixel producers, with
// bounded burst locking. Per-requester beat counters are built when VMEM_ARB_STAT_EN is defined.
module vmem_write_arbiter
  import vmem_write_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int AW        = VMEM_AW,
  parameter int DW        = VMEM_DW,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  input  logic [NREQ-1:0]    w_req_valid,
  input  logic [NREQ-1:0]    w_req_lock,
  input  logic [NREQ*AW-1:0] w_req_adr,
  input  logic [NREQ*DW-1:0] w_req_data,
  output logic [NREQ-1:0]    w_req_ready,
  output logic               w_st_we,
  output logic [AW-1:0]      w_st_wadr,
  output logic [DW-1:0]      w_st_wdata,
  output logic [IW-1:0]      w_owner,
  output logic               w_locked
`ifdef VMEM_ARB_STAT_EN
  ,
  input  logic               w_stat_clr,
  output logic [NREQ*32-1:0] w_stat_cnt
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);
  localparam logic [IW-1:0] OWNER_RST  = IW'(NREQ - 1);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] wadr_q, wadr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] ready;
  logic [IW-1:0]   sel;
  logic            xfer;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (w_req_valid),
    .last  (owner_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // In BURST only the owner may move; ready is forced low while reset is asserted.
  always_comb begin
    ready = '0;
    sel   = owner_q;
    xfer  = 1'b0;
    if (w_rst_n) begin
      if (state_q == ST_ARB) begin
        ready = pick_grant;
        sel   = pick_idx;
        xfer  = pick_any;
      end else begin
        ready[owner_q] = w_req_valid[owner_q];
        xfer           = w_req_valid[owner_q];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == ST_ARB) begin
      if (xfer) begin
        owner_d = sel;
        if (w_req_lock[sel] && (MAX_BURST > 1)) begin
          state_d = ST_BURST;
          cnt_d   = CW'(1);
        end
      end
    end else if (xfer && w_req_lock[owner_q] && ((cnt_q + CW'(1)) != BURST_LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      // Lock released, burst limit hit, or owner idle: owner now has lowest priority.
      state_d = ST_ARB;
      cnt_d   = '0;
    end
    we_d    = xfer;
    wadr_d  = xfer ? w_req_adr[sel*AW +: AW] : wadr_q;
    wdata_d = xfer ? w_req_data[sel*DW +: DW] : wdata_q;
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q <= ST_ARB;
      owner_q <= OWNER_RST;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
    end
  end

  assign w_req_ready = ready;
  assign w_st_we     = we_q;
  assign w_st_wadr   = wadr_q;
  assign w_st_wdata  = wdata_q;
  assign w_owner     = owner_q;
  assign w_locked    = (state_q == ST_BURST);

`ifdef VMEM_ARB_STAT_EN
  logic [NREQ-1:0][31:0] stat_q, stat_d;

  // Clear beats a simultaneous transfer.
  always_comb begin
    stat_d = stat_q;
    if (w_stat_clr) begin
      stat_d = '0;
    end else if (xfer) begin
      stat_d[sel] = stat_q[sel] + 32'd1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign w_stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Directed scoreboard bench for vmem_write_arbiter (NREQ=4, MAX_BURST=16); the counter
// checks are built when VMEM_ARB_STAT_EN is defined.
module tb_vmem_write_arbiter;
  import vmem_write_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic [3:0]  w_req_valid = '0;
  logic [3:0]  w_req_lock = '0;
  logic [63:0] w_req_adr = '0;
  logic [63:0] w_req_data = '0;
  logic [3:0]  w_req_ready;
  logic        w_st_we;
  logic [15:0] w_st_wadr;
  logic [15:0] w_st_wdata;
  logic [1:0]  w_owner;
  logic        w_locked;
`ifdef VMEM_ARB_STAT_EN
  logic         w_stat_clr = 1'b0;
  logic [127:0] w_stat_cnt;
`endif

  vmem_write_arbiter #(.NREQ(4), .MAX_BURST(16), .AW(16), .DW(16)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_req_valid (w_req_valid),
    .w_req_lock  (w_req_lock),
    .w_req_adr   (w_req_adr),
    .w_req_data  (w_req_data),
    .w_req_ready (w_req_ready),
    .w_st_we     (w_st_we),
    .w_st_wadr   (w_st_wadr),
    .w_st_wdata  (w_st_wdata),
    .w_owner     (w_owner),
    .w_locked    (w_locked)
`ifdef VMEM_ARB_STAT_EN
    ,
    .w_stat_clr  (w_stat_clr),
    .w_stat_cnt  (w_stat_cnt)
`endif
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] data;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] adr_v[NREQ];
  logic [15:0] dat_v[NREQ];
  int          seq[NREQ];
  int          stat_exp[NREQ];
  logic [1:0]  owner_exp;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_beats();
    for (int i = 0; i < NREQ; i++) begin
      adr_v[i] = pack_yx(8'(seq[i]), 8'(i * 16 + 3));
      dat_v[i] = 16'(16'h1000 * (i + 1) + seq[i]);
    end
  endtask

  // One cycle: drive, check ready mid-cycle, then check the registered write after the edge.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] lock,
                               input logic [3:0] exp_grant, input logic exp_locked,
                               input bit keep);
    beat_t e;
    int    g;
    if (!keep) refresh_beats();
    for (int i = 0; i < NREQ; i++) begin
      w_req_adr[i*16 +: 16]  = adr_v[i];
      w_req_data[i*16 +: 16] = dat_v[i];
    end
    w_req_valid = valid;
    w_req_lock  = lock;
    g = -1;
    for (int i = 0; i < NREQ; i++) if (exp_grant[i]) g = i;
    e.we   = (g >= 0);
    e.adr  = (g >= 0) ? adr_v[g] : 16'h0;
    e.data = (g >= 0) ? dat_v[g] : 16'h0;
    sb.push_back(e);
    @(negedge w_clk);
    checkOutput("ready", 32'(w_req_ready), 32'(exp_grant));
    @(posedge w_clk);
    #1;
    if (g >= 0) begin
      owner_exp = 2'(g);
      seq[g]++;
      stat_exp[g]++;
    end
`ifdef VMEM_ARB_STAT_EN
    if (w_stat_clr) for (int i = 0; i < NREQ; i++) stat_exp[i] = 0;
`endif
    e = sb.pop_front();
    checkOutput("we", 32'(w_st_we), 32'(e.we));
    if (e.we) begin
      checkOutput("wadr", 32'(w_st_wadr), 32'(e.adr));
      checkOutput("wdata", 32'(w_st_wdata), 32'(e.data));
    end
    checkOutput("owner", 32'(w_owner), 32'(owner_exp));
    checkOutput("locked", 32'(w_locked), 32'(exp_locked));
  endtask

  task automatic do_reset();
    w_rst_n     = 1'b0;
    w_req_valid = 4'hF;
    w_req_lock  = 4'hF;
    @(negedge w_clk);
    checkOutput("rst_ready", 32'(w_req_ready), 32'h0);
    @(posedge w_clk);
    #1;
    checkOutput("rst_we", 32'(w_st_we), 32'h0);
    checkOutput("rst_wadr", 32'(w_st_wadr), 32'h0);
    checkOutput("rst_wdata", 32'(w_st_wdata), 32'h0);
    checkOutput("rst_locked", 32'(w_locked), 32'h0);
    checkOutput("rst_owner", 32'(w_owner), 32'h3);
`ifdef VMEM_ARB_STAT_EN
    for (int i = 0; i < NREQ; i++) checkOutput("rst_stat", w_stat_cnt[i*32 +: 32], 32'h0);
`endif
    w_rst_n     = 1'b1;
    w_req_valid = '0;
    w_req_lock  = '0;
    owner_exp   = 2'd3;
    sb.delete();
    for (int i = 0; i < NREQ; i++) stat_exp[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      stat_exp[i] = 0;
    end
    do_reset();

    // Single requester with a fixed beat
    refresh_beats();
    adr_v[2] = 16'h0A05;
    dat_v[2] = RGB565_RED;
    applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Strict rotation with everyone valid
    do_reset();
    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b0);

    // Burst limit: 16 beats to 1 (lock on the 16th ignored), one to 3, then 1 resumes
    do_reset();
    for (int k = 0; k < 16; k++)
      applyStimulus(4'b1010, 4'b0010, 4'b0010, (k < 15), 1'b0);
    applyStimulus(4'b1010, 4'b0010, 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Burst owner goes idle after 5 beats while requester 0 waits
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);

    // Reset in the middle of a burst
    applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
    do_reset();
    applyStimulus(4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b0);

`ifdef VMEM_ARB_STAT_EN
    do_reset();
    for (int k = 0; k < 10; k++) applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < NREQ; i++) checkOutput("stat", w_stat_cnt[i*32 +: 32], 32'(stat_exp[i]));
    w_stat_clr = 1'b1;
    applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
    w_stat_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) checkOutput("stat_clr", w_stat_cnt[i*32 +: 32], 32'(stat_exp[i]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmem_write_arbiter.md
Name: vmem_write_arbiter

Overview:
- Shares the single video-memory write port (write enable, 16-bit address {y,x}, 16-bit RGB565 data) between NREQ independent pixel producers, e.g. pattern generator, sprite engine, text overlay, fill engine.
- Round-robin arbitration with a valid/ready handshake.
- Optional bounded burst locking, so a producer can write a run of pixels without interleaving.
- Registered output drives the vmem write port directly; the display refresh read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive beats one requester may hold the port under lock (1..256); 1 disables locking.
- AW, 16, address width ({y[7:0],x[7:0]}).
- DW, 16, pixel data width (RGB565).

Ports:
- w_clk  in  1  main clock (100MHz).
- w_rst_n  in  1  synchronous active-low reset.
- w_req_valid  in  NREQ  per-requester beat valid.
- w_req_lock  in  NREQ  per-requester: keep grant after this beat.
- w_req_adr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- w_req_data  in  NREQ*DW  packed pixel data; requester i at [i*DW +: DW].
- w_req_ready  out  NREQ  one-hot or zero: beat accepted this cycle when valid&ready.
- w_st_we  out  1  vmem write enable.
- w_st_wadr  out  AW  vmem write address.
- w_st_wdata  out  DW  vmem write data.
- w_owner  out  $clog2(NREQ)  index of the most recently granted requester.
- w_locked  out  1  high while in BURST state.

Behaviour:
- Reset (w_rst_n=0 at a w_clk edge):
  - w_st_we=0, w_st_wadr=0, w_st_wdata=0, w_locked=0, burst count=0.
  - w_owner=NREQ-1, so requester 0 wins first.
  - State ARB.
  - Reset mid-burst drops the lock immediately; the beat registered that same cycle is discarded (w_st_we=0 next cycle).
- w_req_ready:
  - Combinational from state, w_owner and w_req_valid.
  - At most one bit set.
  - Never set for a requester whose valid is low.
  - Held at 0 during reset.
- Transfer: w_req_valid[i] & w_req_ready[i]. Requesters must hold adr/data/lock stable while valid and not ready.
- Latency: a transfer in cycle N gives w_st_we=1 with that beat's adr/data in cycle N+1. No transfer in cycle N gives w_st_we=0 in cycle N+1; adr/data hold their last values.
- Throughput: one beat per cycle, no bubbles between grants.
- State ARB:
  - Winner is the first valid requester searching (w_owner+1) mod NREQ upward, with wrap.
  - ready[winner]=1 and w_owner<=winner on transfer.
  - Winner lock=1 and MAX_BURST>1: go to BURST with count=1.
  - Otherwise stay in ARB.
  - No valid requester: no grant; w_owner unchanged.
- State BURST:
  - Only w_owner is eligible; ready[owner]=valid[owner].
  - On transfer, count++.
  - Return to ARB when:
    - the beat has lock=0, or
    - count reaches MAX_BURST (that beat is still accepted), or
    - valid[owner]=0 for one cycle (no transfer that cycle).
  - On return, the next ARB search starts after w_owner, so the burst owner gets lowest priority.
- Fairness: any continuously valid requester is granted within (NREQ-1)*MAX_BURST+1 cycles.
- Simultaneous events: every requester valid in ARB → strict rotation 0,1,2,...,NREQ-1,0. A lock request on the MAX_BURST-th beat is ignored.
- No address checking: overlapping writes land in grant order.

Optional Feature:
- VMEM_ARB_STAT_EN defined adds:
  - output w_stat_cnt (NREQ*32), one wrapping 32-bit counter per requester, incremented on each accepted beat;
  - input w_stat_clr (1), which clears all counters synchronously;
  - counters are reset to 0 by w_rst_n;
  - if a clear and a transfer happen in the same cycle, the result is 0.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package: AW/DW defaults, RGB565 colour constants, the {y,x} address-packing helper, and the ARB/BURST state encoding.
- One natural sub-module, rr_pick: combinational round-robin priority picker taking a request vector and the last index, returning a one-hot grant and its index. It is reusable by other shared-resource arbiters.

Test Plan:
- Reset then single requester: valid[2]=1, adr=16'h0A05, data=16'hF800 → ready[2] same cycle; next cycle w_st_we=1, wadr=16'h0A05, wdata=16'hF800, w_owner=2.
- All four valid continuously, lock=0 → grants 0,1,2,3,0,1 on consecutive cycles; w_st_we=1 every cycle after the first.
- Requester 1 lock=1 for 40 beats, requester 3 valid, MAX_BURST=16 → 16 consecutive grants to 1, then one to 3, then 1 resumes; w_locked high during the 15 BURST cycles.
- Burst owner drops valid after 5 beats while requester 0 waits → BURST exits; the next cycle grants 0; no write is issued in the gap cycle.
- Reset asserted mid-burst, with a beat accepted that same cycle → next cycle w_st_we=0, w_locked=0, w_owner=3; the first post-reset grant goes to the lowest valid index.
- With VMEM_ARB_STAT_EN: 10 beats from requester 0 and 3 from requester 2 → counters 10,0,3,0; pulse w_stat_clr coincident with a transfer → all counters 0.
